// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage 16-bit RISC pipeline.
// Boots by loading the 32-bit reset vector from imem, then fetches one
// word per cycle, pairing two-word (immediate) instructions before they
// are handed to decode. Handles stall, flush and redirects from execute
// and memory stages.
// Optional build macro FETCH_INT_LATCH_EN: latch interrupt requests and
// tag them onto the next real instruction instead of sampling them raw.
module fetch_stage #(
    parameter int                     PC_WIDTH       = 32,
    parameter int                     INSTR_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_VEC_ADDR = '0,
    parameter int                     IMM_BIT        = 15,
    parameter logic [INSTR_WIDTH-1:0] NOP            = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   jump_taken,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   pc_choose_memory,
    input  logic [PC_WIDTH-1:0]    mem_pc,
    input  logic                   interrupt_in,
    output logic [INSTR_WIDTH-1:0] instruction_r,
    output logic [INSTR_WIDTH-1:0] immediate_r,
    output logic [PC_WIDTH-1:0]    PC_r,
    output logic                   interrupt_signal_r,
    output logic                   valid_r
);

    localparam logic [1:0] BOOT_HI = 2'd0;
    localparam logic [1:0] BOOT_LO = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] IMM     = 2'd3;

    localparam logic [PC_WIDTH-1:0] ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [INSTR_WIDTH-1:0] first_word;
    logic [PC_WIDTH-1:0]    first_pc;
    logic                   running;
    logic                   redirect;
    logic                   advance;

    assign pc_inc   = pc + ONE;
    assign running  = (state == RUN) || (state == IMM);
    assign redirect = pc_choose_memory || jump_taken;
    // A redirect wins over stall, so the stage moves on any redirect cycle.
    assign advance  = running && (redirect || !stall);

    // Fetch address: reset-vector words while booting, the PC afterwards.
    always_comb begin
        imem_addr = pc;
        case (state)
            BOOT_HI: imem_addr = RESET_VEC_ADDR;
            BOOT_LO: imem_addr = RESET_VEC_ADDR + ONE;
            default: imem_addr = pc;
        endcase
    end

    // Boot, PC sequencing, two-word assembly and decode-facing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT_HI;
            pc            <= '0;
            first_word    <= '0;
            first_pc      <= '0;
            instruction_r <= NOP;
            immediate_r   <= '0;
            PC_r          <= '0;
            valid_r       <= 1'b0;
        end else begin
            case (state)
                BOOT_HI: begin
                    pc[PC_WIDTH-1 -: INSTR_WIDTH] <= imem_data;
                    state                         <= BOOT_LO;
                end
                BOOT_LO: begin
                    pc[INSTR_WIDTH-1:0] <= imem_data;
                    state               <= RUN;
                end
                default: begin
                    if (redirect) begin
                        // Memory-stage redirect (RET/RTI/INT) outranks a branch.
                        pc            <= pc_choose_memory ? mem_pc : jump_target;
                        instruction_r <= NOP;
                        immediate_r   <= '0;
                        valid_r       <= 1'b0;
                        state         <= RUN;
                    end else if (stall) begin
                        // Hold everything.
                    end else if (flush) begin
                        instruction_r <= NOP;
                        valid_r       <= 1'b0;
                        // Squashing an immediate word drops the half-built
                        // pair; refetch from its first word.
                        if (state == IMM) begin
                            pc    <= first_pc;
                            state <= RUN;
                        end
                    end else if (state == IMM) begin
                        instruction_r <= first_word;
                        immediate_r   <= imem_data;
                        PC_r          <= pc_inc;
                        pc            <= pc_inc;
                        valid_r       <= 1'b1;
                        state         <= RUN;
                    end else if (imem_data[IMM_BIT]) begin
                        first_word    <= imem_data;
                        first_pc      <= pc;
                        pc            <= pc_inc;
                        instruction_r <= NOP;
                        valid_r       <= 1'b0;
                        state         <= IMM;
                    end else begin
                        instruction_r <= imem_data;
                        immediate_r   <= '0;
                        PC_r          <= pc_inc;
                        pc            <= pc_inc;
                        valid_r       <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_INT_LATCH_EN
    logic pending;
    logic emit;

    // A real instruction leaves this cycle: normal one-word fetch or an
    // immediate word completing a pair.
    assign emit = advance && !redirect && !flush &&
                  ((state == IMM) || !imem_data[IMM_BIT]);

    // Remember any request until it can ride on a real instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending            <= 1'b0;
            interrupt_signal_r <= 1'b0;
        end else begin
            if (interrupt_in) begin
                pending <= 1'b1;
            end else if (emit) begin
                pending <= 1'b0;
            end
            if (advance) begin
                interrupt_signal_r <= emit && pending;
            end
        end
    end
`else
    // Raw sampling: the request follows the pipeline whenever it advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt_signal_r <= 1'b0;
        end else if (advance) begin
            interrupt_signal_r <= interrupt_in;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle inputs and expected
// outputs, followed by hand-written sequences for async reset mid-pair
// and interrupt tagging.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        jump_taken = 1'b0;
    logic [31:0] jump_target = '0;
    logic        pc_choose_memory = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        interrupt_in = 1'b0;
    logic [15:0] instruction_r;
    logic [15:0] immediate_r;
    logic [31:0] PC_r;
    logic        interrupt_signal_r;
    logic        valid_r;

    logic [15:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_INT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .stall             (stall),
        .flush             (flush),
        .jump_taken        (jump_taken),
        .jump_target       (jump_target),
        .pc_choose_memory  (pc_choose_memory),
        .mem_pc            (mem_pc),
        .interrupt_in      (interrupt_in),
        .instruction_r     (instruction_r),
        .immediate_r       (immediate_r),
        .PC_r              (PC_r),
        .interrupt_signal_r(interrupt_signal_r),
        .valid_r           (valid_r)
    );

    assign imem_data = mem[imem_addr[9:0]];

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        jt;
        logic        pm;
        logic [31:0] tgt;
        logic [31:0] mpc;
        logic        ev;
        logic [15:0] ei;
        logic [15:0] eimm;
        logic [31:0] epcr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic st, input logic fl, input logic jt,
                                input logic pm, input logic [31:0] tgt,
                                input logic [31:0] mpc, input logic ev,
                                input logic [15:0] ei, input logic [15:0] eimm,
                                input logic [31:0] epcr, input logic [31:0] eaddr);
        vec_t v;
        v.st = st; v.fl = fl; v.jt = jt; v.pm = pm; v.tgt = tgt; v.mpc = mpc;
        v.ev = ev; v.ei = ei; v.eimm = eimm; v.epcr = epcr; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after it.
    task automatic step(input logic st, input logic fl, input logic jt, input logic pm,
                        input logic [31:0] tgt, input logic [31:0] mpc, input logic intr);
        stall = st; flush = fl; jump_taken = jt; pc_choose_memory = pm;
        jump_target = tgt; mem_pc = mpc; interrupt_in = intr;
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0; jump_taken = 1'b0; pc_choose_memory = 1'b0;
        interrupt_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h0000;
        mem[1]     = 16'h0040;
        mem[10'h040] = 16'h1234;
        mem[10'h041] = 16'h2345;
        mem[10'h042] = 16'h3456;
        mem[10'h043] = 16'h8A00;
        mem[10'h044] = 16'hBEEF;
        mem[10'h045] = 16'h0555;
        mem[10'h046] = 16'h8B00;
        mem[10'h047] = 16'hC0DE;
        mem[10'h048] = 16'h0777;
        mem[10'h100] = 16'h0100;
        mem[10'h101] = 16'h0101;
        mem[10'h200] = 16'h0200;
        mem[10'h201] = 16'h8C00;
        mem[10'h202] = 16'h1111;
        mem[10'h203] = 16'h0333;
        mem[10'h3FF] = 16'h0999;

        //             st fl jt pm tgt            mpc            ev ei        eimm      epcr           eaddr
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h0,        32'h1);
        tbl[1]  = mk(0, 0, 1, 0, 32'h100,      32'h0,       0, 16'h0000, 16'h0000, 32'h0,        32'h40);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h1234, 16'h0000, 32'h41,       32'h41);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h2345, 16'h0000, 32'h42,       32'h42);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h3456, 16'h0000, 32'h43,       32'h43);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h43,       32'h44);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h8A00, 16'hBEEF, 32'h45,       32'h45);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0555, 16'h0000, 32'h46,       32'h46);
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0555, 16'h0000, 32'h46,       32'h46);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h46,       32'h47);
        tbl[10] = mk(1, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h46,       32'h47);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h46,       32'h47);
        tbl[12] = mk(1, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h46,       32'h47);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h8B00, 16'hC0DE, 32'h48,       32'h48);
        tbl[14] = mk(0, 1, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h48,       32'h48);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0777, 16'h0000, 32'h49,       32'h49);
        tbl[16] = mk(0, 0, 1, 0, 32'h100,      32'h0,       0, 16'h0000, 16'h0000, 32'h49,       32'h100);
        tbl[17] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0100, 16'h0000, 32'h101,      32'h101);
        tbl[18] = mk(1, 0, 1, 1, 32'h100,      32'h200,     0, 16'h0000, 16'h0000, 32'h101,      32'h200);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0200, 16'h0000, 32'h201,      32'h201);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h201,      32'h202);
        tbl[21] = mk(0, 1, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h201,      32'h201);
        tbl[22] = mk(0, 0, 0, 0, 32'h0,        32'h0,       0, 16'h0000, 16'h0000, 32'h201,      32'h202);
        tbl[23] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h8C00, 16'h1111, 32'h203,      32'h203);
        tbl[24] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0333, 16'h0000, 32'h204,      32'h204);
        tbl[25] = mk(0, 0, 1, 0, 32'hFFFFFFFF, 32'h0,       0, 16'h0000, 16'h0000, 32'h204,      32'hFFFFFFFF);
        tbl[26] = mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 16'h0999, 16'h0000, 32'h0,        32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_r), 32'h0);
        chk("rst_instr", 32'(instruction_r), 32'h0);
        chk("rst_imm", 32'(immediate_r), 32'h0);
        chk("rst_pcr", PC_r, 32'h0);
        chk("rst_int", 32'(interrupt_signal_r), 32'h0);
        reset = 1'b1;
        chk("boot_hi_addr", imem_addr, 32'h0);

        // Table-driven main run
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].st, tbl[i].fl, tbl[i].jt, tbl[i].pm, tbl[i].tgt, tbl[i].mpc, 1'b0);
            chk($sformatf("row%0d_valid", i), 32'(valid_r), 32'(tbl[i].ev));
            chk($sformatf("row%0d_instr", i), 32'(instruction_r), 32'(tbl[i].ei));
            chk($sformatf("row%0d_pcr", i), PC_r, tbl[i].epcr);
            chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("row%0d_int", i), 32'(interrupt_signal_r), 32'h0);
            if (tbl[i].ev)
                chk($sformatf("row%0d_imm", i), 32'(immediate_r), 32'(tbl[i].eimm));
        end

        // Async reset while mid-pair
        step(0, 0, 1, 0, 32'h43, 32'h0, 0);
        chk("pre_rst_addr", imem_addr, 32'h43);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("pre_rst_imm_addr", imem_addr, 32'h44);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_r), 32'h0);
        chk("arst_instr", 32'(instruction_r), 32'h0);
        chk("arst_pcr", PC_r, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reboot_hi_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("reboot_lo_addr", imem_addr, 32'h1);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("reboot_run_addr", imem_addr, 32'h40);
        chk("reboot_no_valid", 32'(valid_r), 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("reboot_valid", 32'(valid_r), 32'h1);
        chk("reboot_instr", 32'(instruction_r), 32'h1234);
        chk("reboot_pcr", PC_r, 32'h41);

        // Interrupt pulse during stall
        step(1, 0, 0, 0, 32'h0, 32'h0, 1);
        chk("istall1_instr", 32'(instruction_r), 32'h1234);
        chk("istall1_int", 32'(interrupt_signal_r), 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("istall2_int", 32'(interrupt_signal_r), 32'h0);
        chk("istall2_addr", imem_addr, 32'h41);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("irel_instr", 32'(instruction_r), 32'h2345);
        chk("irel_int", 32'(interrupt_signal_r), 32'(LATCH));
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("inext_instr", 32'(instruction_r), 32'h3456);
        chk("inext_int", 32'(interrupt_signal_r), 32'h0);

        // Interrupt pulse on the first word of a pair
        step(0, 0, 0, 0, 32'h0, 32'h0, 1);
        chk("ipair_bubble_valid", 32'(valid_r), 32'h0);
        chk("ipair_bubble_int", 32'(interrupt_signal_r), 32'(!LATCH));
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("ipair_instr", 32'(instruction_r), 32'h8A00);
        chk("ipair_imm", 32'(immediate_r), 32'hBEEF);
        chk("ipair_int", 32'(interrupt_signal_r), 32'(LATCH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit RISC pipeline.
- Produces the instruction, immediate, next-PC and interrupt tag registered into the decode stage, which is the consumer of this interface.
- Owns the 32-bit PC and a boot sequence that loads the reset vector from instruction memory.
- Assembles two-word (immediate) instructions and handles stall, flush and redirects from later stages.

Parameters:
PC_WIDTH, 32, width of PC and all address/target buses
INSTR_WIDTH, 16, instruction word width
RESET_VEC_ADDR, 0, imem address of reset-vector high word; low word at RESET_VEC_ADDR+1
IMM_BIT, 15, instruction bit that marks a two-word instruction
NOP, 16'h0000, bubble encoding

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_addr  out  PC_WIDTH  instruction memory address (combinational from state/PC)
imem_data  in  INSTR_WIDTH  instruction memory read data, same-cycle (async read)
stall  in  1  hazard stall: hold all state
flush  in  1  squash the word fetched this cycle
jump_taken  in  1  branch/jump redirect from execute
jump_target  in  PC_WIDTH  branch target
pc_choose_memory  in  1  redirect from memory stage (RET/RTI/INT vector)
mem_pc  in  PC_WIDTH  PC popped/read from memory
interrupt_in  in  1  external interrupt request
instruction_r  out  INSTR_WIDTH  registered instruction to decode
immediate_r  out  INSTR_WIDTH  registered immediate (0 for one-word instructions)
PC_r  out  PC_WIDTH  address following the emitted instruction (return address for CALL/INT)
interrupt_signal_r  out  1  interrupt tag aligned with instruction_r
valid_r  out  1  instruction_r holds a real instruction

Behaviour:
- Reset (async, reset==0): FSM=BOOT_HI, pc=0, first_word=0, first_pc=0, instruction_r=NOP, immediate_r=0, PC_r=0, interrupt_signal_r=0, valid_r=0, pending=0. Reset mid-operation discards any half-assembled instruction.
- FSM states: BOOT_HI, BOOT_LO, RUN, IMM.
- BOOT_HI: imem_addr=RESET_VEC_ADDR; pc[31:16]<=imem_data; ->BOOT_LO.
- BOOT_LO: imem_addr=RESET_VEC_ADDR+1; pc[15:0]<=imem_data; ->RUN.
- During boot: outputs hold their reset values; stall, flush, jump_taken and pc_choose_memory are ignored.
- RUN/IMM: imem_addr=pc.
- Priority each cycle in RUN/IMM: pc_choose_memory > jump_taken > stall > flush > normal.
- Redirect (pc_choose_memory or jump_taken): pc<=mem_pc or jump_target; instruction_r<=NOP; immediate_r<=0; valid_r<=0; ->RUN. Redirect overrides stall.
- Stall: every register holds, including outputs and FSM.
- Flush in RUN: instruction_r<=NOP; valid_r<=0; pc holds (word refetched).
- Flush in IMM: pc<=first_pc; NOP; valid_r<=0; ->RUN.
- Normal in RUN with imem_data[IMM_BIT]==0:
  - instruction_r<=imem_data; immediate_r<=0; PC_r<=pc+1; pc<=pc+1; valid_r<=1.
- Normal in RUN with imem_data[IMM_BIT]==1:
  - first_word<=imem_data; first_pc<=pc; pc<=pc+1; emit NOP with valid_r=0; ->IMM.
- Normal in IMM:
  - instruction_r<=first_word; immediate_r<=imem_data; PC_r<=pc+1; pc<=pc+1; valid_r<=1; ->RUN.
- Latency: one-word instruction appears at decode 1 cycle after fetch. Two-word instruction appears 2 cycles after its first word is fetched, with exactly one bubble.
- PC arithmetic: modulo 2^PC_WIDTH; 0xFFFFFFFF+1 wraps to 0.
- The IMM_BIT test is applied only to first words, never to an immediate word.

Optional Feature:
- Macro: FETCH_INT_LATCH_EN.
- Defined:
  - pending is set on any cycle with interrupt_in==1, including boot and stall.
  - On the next cycle that emits valid_r=1, interrupt_signal_r<=1 and pending clears, unless interrupt_in is high again that cycle.
  - interrupt_signal_r is 0 on all other emissions.
  - Interrupt tagging never lands on a bubble or mid-IMM.
- Undefined:
  - interrupt_signal_r<=interrupt_in on every non-stalled RUN/IMM cycle, regardless of valid_r.
  - Interrupt pulses during stall or boot are lost.

Test Plan:
- Boot: imem[0]=0x0000, imem[1]=0x0040, reset released -> cycle 2 imem_addr=0x40; first valid_r=1 on cycle 3 with instruction_r=imem[0x40], PC_r=0x41.
- One-word stream: imem[0x40..0x42]=0x1234,0x2345,0x3456 -> three consecutive valid outputs, PC_r=0x41, 0x42, 0x43, immediate_r=0.
- Two-word: imem[0x40]=0x8A00, imem[0x41]=0xBEEF -> one NOP (valid_r=0), then instruction_r=0x8A00, immediate_r=0xBEEF, PC_r=0x42.
- Stall 3 cycles mid-IMM, then release -> outputs and pc frozen during stall; then emits 0x8A00/0xBEEF with PC_r=0x42, no duplicate.
- Simultaneous stall=1, jump_taken=1 (0x100), pc_choose_memory=1 (0x200) -> pc=0x200, NOP, valid_r=0. Next cycle imem_addr=0x200. Async reset asserted in IMM -> all outputs reset immediately, boot restarts.
- FETCH_INT_LATCH_EN defined: 1-cycle interrupt_in pulse during stall -> interrupt_signal_r=1 on the first valid emission after stall release, 0 on the following one. Undefined: same stimulus -> interrupt_signal_r never asserts.
